bus_cycle_ctrl: RTL and testbench
=================================

// Module: bus_cycle_ctrl
// PURPOSE
//  Downstream of the interface top. Converts one OP/Direction/Data request into a
//  multi-cycle external bus transaction: 20-bit address, 8-bit data.
//  Phases: T1 address/ALE, T2 strobe, T3 sample, TW waits, T4 release.
//  Returns read data and completion or error status to the requester.
// PARAMETERS
//  ADDR_W      20  address width (Direction, bus_addr)
//  DATA_W      8   data width (Data, bus_wdata, bus_rdata, rdata)
//  WAIT_MAX    15  max wait states before timeout abort (1..2**WAIT_CNT_W-1)
//  WAIT_CNT_W  4   wait counter width
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high reset
//  OP          in   3       000 NOP, 001 MEM_RD, 010 MEM_WR, 011 IO_RD, 100 IO_WR, others illegal
//  op_valid    in   1       request present on OP/Direction/Data
//  op_ready    out  1       1 only in IDLE; request accepted when op_valid&op_ready
//  Direction   in   ADDR_W  request address
//  Data        in   DATA_W  write data
//  bus_addr    out  ADDR_W  external address
//  bus_ale     out  1       address latch enable
//  bus_io_m    out  1       1 = IO space, 0 = memory
//  bus_rd      out  1       read strobe
//  bus_wr      out  1       write strobe
//  bus_wdata   out  DATA_W  write data; valid while bus_wr=1
//  bus_ready   in   1       slave ready; sampled in T3 and TW
//  bus_rdata   in   DATA_W  slave read data
//  rdata       out  DATA_W  captured read data; held until the next read capture
//  done        out  1       1-cycle completion pulse
//  rdata_valid out  1       1-cycle pulse with done on a successful read
//  err         out  1       1-cycle pulse: illegal OP or wait timeout
// BEHAVIOUR
//  - All outputs registered. Reset (sync) -> state IDLE; op_ready=1; all other outputs 0.
//  - Direction, Data, OP latched on accept and held stable through T4.
//  - bus_addr holds the latched address until the next accept.
//  - Accept at edge n. IDLE->T1 (n+1): bus_ale=1, bus_addr and bus_io_m valid.
//  - T1->T2 (n+2): ale=0; bus_rd (reads) or bus_wr (writes) =1.
//  - T2->T3 (n+3): strobe held.
//  - In T3/TW: bus_ready=1 -> next T4, capture bus_rdata on reads; else -> TW, wait_cnt++.
//  - T4: strobes=0, done=1, rdata_valid=1 for reads. T4->IDLE.
//  - Zero-wait latency: done is seen 4 cycles after accept; next accept 1 cycle after done.
//  - Timeout: in TW, bus_ready=0 with wait_cnt==WAIT_MAX -> next T4 with done=1, err=1.
//    On timeout abort: rdata_valid=0 and rdata unchanged.
//  - wait_cnt clears on accept and saturates; it never wraps.
//  - NOP: accepted, no bus cycle, no done/err, stays IDLE.
//  - Illegal OP: accepted, no bus cycle; next cycle done=1, err=1; stays IDLE with op_ready=1.
//  - op_valid outside IDLE: ignored; the requester must hold the request until op_ready.
//  - bus_ready outside T3/TW: ignored.
//  - bus_rd and bus_wr are never 1 simultaneously.
//  - reset in any state (incl. TW): next edge IDLE, strobes 0, no done/err emitted.
// TESTING
//  1 MEM_RD A=0xABCDE, bus_ready=1, rdata=0x5A -> ale@n+1, rd@n+2..n+3,
//    done+rdata_valid@n+4, rdata=0x5A, io_m=0.
//  2 IO_WR A=0x003F8 D=0xC3, bus_ready low 2 cycles -> wr high n+2..n+5, wdata=0xC3,
//    io_m=1, done@n+6, err=0.
//  3 MEM_RD, bus_ready stuck 0 -> WAIT_MAX TW cycles, then done=1 err=1 rdata_valid=0,
//    rdata keeps its old value.
//  4 OP=111 -> done=err=1 the next cycle, no strobe/ale; OP=000 -> no pulses at all.
//  5 Back-to-back MEM_WR 0x00001/MEM_RD 0xFFFFF, op_valid held -> second accept 1 cycle
//    after first done; addresses correct.
//  6 reset asserted during TW of IO_RD -> next cycle IDLE, rd=0, op_ready=1, done/err=0;
//    next request runs normally.

Source files
------------

// File: rtl/bus_cycle_ctrl_if.sv
// bus_cycle_ctrl_if: request/response handshake plus external bus pins
// for the bus cycle controller.
interface bus_cycle_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic [2:0]        OP;
    logic              op_valid;
    logic              op_ready;
    logic [ADDR_W-1:0] Direction;
    logic [DATA_W-1:0] Data;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ale;
    logic              bus_io_m;
    logic              bus_rd;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              rdata_valid;
    logic              err;

    // requester + external slave side
    modport master (
        output OP, op_valid, Direction, Data, bus_ready, bus_rdata,
        input  op_ready, bus_addr, bus_ale, bus_io_m, bus_rd, bus_wr,
        input  bus_wdata, rdata, done, rdata_valid, err
    );

    // controller side
    modport slave (
        input  OP, op_valid, Direction, Data, bus_ready, bus_rdata,
        output op_ready, bus_addr, bus_ale, bus_io_m, bus_rd, bus_wr,
        output bus_wdata, rdata, done, rdata_valid, err
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: turns one OP/Direction/Data request into a
// T1/T2/T3/TW/T4 external bus cycle with a wait-state timeout.
module bus_cycle_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 8,
    parameter int WAIT_MAX   = 15,
    parameter int WAIT_CNT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    bus_cycle_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MRD  = 3'b001;
    localparam logic [2:0] OP_MWR  = 3'b010;
    localparam logic [2:0] OP_IORD = 3'b011;
    localparam logic [2:0] OP_IOWR = 3'b100;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_MAX);

    state_t                state;
    state_t                state_nx;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nx;
    logic [2:0]            op_q;

    logic accept;
    logic req_bus;
    logic req_io;
    logic q_rd;
    logic q_wr;
    logic ale_nx;
    logic rd_nx;
    logic wr_nx;
    logic done_nx;
    logic rv_nx;
    logic err_nx;
    logic ready_nx;
    logic capture;

    assign accept  = bus.op_valid & bus.op_ready;
    assign req_bus = (bus.OP == OP_MRD)  | (bus.OP == OP_MWR) |
                     (bus.OP == OP_IORD) | (bus.OP == OP_IOWR);
    assign req_io  = (bus.OP == OP_IORD) | (bus.OP == OP_IOWR);
    assign q_rd    = (op_q == OP_MRD) | (op_q == OP_IORD);
    assign q_wr    = (op_q == OP_MWR) | (op_q == OP_IOWR);

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Next state plus the values the output registers take next cycle
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        ale_nx      = 1'b0;
        rd_nx       = 1'b0;
        wr_nx       = 1'b0;
        done_nx     = 1'b0;
        rv_nx       = 1'b0;
        err_nx      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    wait_cnt_nx = '0;
                    if (req_bus) begin
                        state_nx = S_T1;
                        ale_nx   = 1'b1;
                    end else if (bus.OP != OP_NOP) begin
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end
                end
            end
            S_T1: begin
                state_nx = S_T2;
                rd_nx    = q_rd;
                wr_nx    = q_wr;
            end
            S_T2: begin
                state_nx = S_T3;
                rd_nx    = q_rd;
                wr_nx    = q_wr;
            end
            S_T3, S_TW: begin
                if (bus.bus_ready) begin
                    state_nx = S_T4;
                    done_nx  = 1'b1;
                    rv_nx    = q_rd;
                    capture  = q_rd;
                end else if (state == S_TW && wait_cnt == WAIT_LIM) begin
                    state_nx = S_T4;
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                end else begin
                    state_nx = S_TW;
                    rd_nx    = q_rd;
                    wr_nx    = q_wr;
                    if (wait_cnt < WAIT_LIM) begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
            end
            S_T4: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        ready_nx = (state_nx == S_IDLE);
    end

    // Output registers and request latches
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q            <= OP_NOP;
            bus.bus_addr    <= {ADDR_W{1'b0}};
            bus.bus_io_m    <= 1'b0;
            bus.bus_wdata   <= {DATA_W{1'b0}};
            bus.bus_ale     <= 1'b0;
            bus.bus_rd      <= 1'b0;
            bus.bus_wr      <= 1'b0;
            bus.done        <= 1'b0;
            bus.rdata_valid <= 1'b0;
            bus.err         <= 1'b0;
            bus.rdata       <= {DATA_W{1'b0}};
            bus.op_ready    <= 1'b1;
        end else begin
            if (accept) begin
                op_q          <= bus.OP;
                bus.bus_addr  <= bus.Direction;
                bus.bus_io_m  <= req_io;
                bus.bus_wdata <= bus.Data;
            end
            if (capture) begin
                bus.rdata <= bus.bus_rdata;
            end
            bus.bus_ale     <= ale_nx;
            bus.bus_rd      <= rd_nx;
            bus.bus_wr      <= wr_nx;
            bus.done        <= done_nx;
            bus.rdata_valid <= rv_nx;
            bus.err         <= err_nx;
            bus.op_ready    <= ready_nx;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed and random bus transactions checked
// cycle by cycle against a timeline model of the bus cycle rules.
module tb_bus_cycle_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int N_RAND   = 40;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0]  rdata_exp;
    logic [2:0]  r_op   [N_RAND];
    logic [19:0] r_addr [N_RAND];
    logic [7:0]  r_data [N_RAND];
    int          r_w    [N_RAND];

    bus_cycle_ctrl_if bus ();

    bus_cycle_ctrl #(
        .ADDR_W(20),
        .DATA_W(8),
        .WAIT_MAX(WAIT_MAX),
        .WAIT_CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {bus.bus_ale, bus.bus_rd, bus.bus_wr, bus.done,
                bus.rdata_valid, bus.err, bus.op_ready};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request from an IDLE negedge; model derives the expected
    // timeline from the op kind and the number of not-ready cycles w.
    task automatic run_txn(input logic [2:0] op, input logic [19:0] a,
                           input logic [7:0] d, input int w,
                           input logic [7:0] rdv, input bit hold,
                           input logic [2:0] n_op, input logic [19:0] n_a,
                           input logic [7:0] n_d, input int rst_k);
        bit is_bus = (op >= 3'd1 && op <= 3'd4);
        bit rd     = (op == 3'd1 || op == 3'd3);
        bit io     = (op == 3'd3 || op == 3'd4);
        bit to     = (w > WAIT_MAX);
        int t      = to ? WAIT_MAX : w;
        int len    = is_bus ? 4 + t : 1;
        bit ale, str, dn, er, rv, rdy;
        bus.OP        = op;
        bus.Direction = a;
        bus.Data      = d;
        bus.op_valid  = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold && is_bus) begin
                    bus.OP        = n_op;
                    bus.Direction = n_a;
                    bus.Data      = n_d;
                end else begin
                    bus.op_valid = 1'b0;
                end
            end
            ale = is_bus && k == 1;
            str = is_bus && k >= 2 && k <= 3 + t;
            dn  = is_bus ? (k == len) : (op != 3'd0);
            er  = dn && (!is_bus || to);
            rv  = dn && is_bus && rd && !to;
            rdy = !is_bus;
            if (rv) rdata_exp = rdv;
            chk($sformatf("ctl op%0d k%0d", op, k), 32'(ctl()),
                32'({ale, str && rd, str && !rd, dn, rv, er, rdy}));
            chk($sformatf("addr k%0d", k), 32'(bus.bus_addr), 32'(a));
            chk($sformatf("rdata k%0d", k), 32'(bus.rdata), 32'(rdata_exp));
            if (is_bus)
                chk($sformatf("io_m k%0d", k), 32'(bus.bus_io_m), 32'(io));
            if (str && !rd)
                chk($sformatf("wdata k%0d", k), 32'(bus.bus_wdata), 32'(d));
            if (is_bus && k >= 3 && k <= 3 + t) begin
                bus.bus_ready = (k - 3 >= w);
                bus.bus_rdata = (k == 3 + t) ? rdv : 8'($urandom);
            end else begin
                bus.bus_ready = 1'($urandom);
                bus.bus_rdata = 8'($urandom);
            end
            if (k == rst_k) begin
                reset        = 1'b1;
                bus.op_valid = 1'b0;
                @(negedge clk);
                reset     = 1'b0;
                rdata_exp = 8'h00;
                chk("rst ctl", 32'(ctl()), 32'h1);
                chk("rst addr", 32'(bus.bus_addr), 32'h0);
                chk("rst rdata", 32'(bus.rdata), 32'h0);
                return;
            end
        end
        @(negedge clk);
        chk("idle ctl", 32'(ctl()), 32'h1);
        chk("idle addr", 32'(bus.bus_addr), 32'(a));
    endtask

    initial begin
        reset         = 1'b1;
        bus.OP        = 3'd0;
        bus.op_valid  = 1'b0;
        bus.Direction = '0;
        bus.Data      = '0;
        bus.bus_ready = 1'b0;
        bus.bus_rdata = '0;
        rdata_exp     = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset ctl", 32'(ctl()), 32'h1);
        chk("reset addr", 32'(bus.bus_addr), 32'h0);
        chk("reset io_m", 32'(bus.bus_io_m), 32'h0);
        chk("reset wdata", 32'(bus.bus_wdata), 32'h0);
        chk("reset rdata", 32'(bus.rdata), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(3'd1, 20'hABCDE, 8'h00, 0, 8'h5A, 0, 0, 0, 0, 0);
        run_txn(3'd4, 20'h003F8, 8'hC3, 2, 8'h00, 0, 0, 0, 0, 0);
        run_txn(3'd1, 20'h12345, 8'h00, WAIT_MAX + 3, 8'h77, 0, 0, 0, 0, 0);
        run_txn(3'd3, 20'h00400, 8'h00, WAIT_MAX, 8'h99, 0, 0, 0, 0, 0);
        run_txn(3'd3, 20'h00401, 8'h00, WAIT_MAX + 1, 8'h11, 0, 0, 0, 0, 0);
        run_txn(3'd7, 20'h55555, 8'h12, 0, 8'h00, 0, 0, 0, 0, 0);
        run_txn(3'd0, 20'h0AAAA, 8'h34, 0, 8'h00, 0, 0, 0, 0, 0);
        run_txn(3'd2, 20'h00001, 8'hAA, 0, 8'h00, 1,
                3'd1, 20'hFFFFF, 8'h00, 0);
        run_txn(3'd1, 20'hFFFFF, 8'h00, 0, 8'h3C, 0, 0, 0, 0, 0);
        run_txn(3'd3, 20'h00100, 8'h00, WAIT_MAX + 2, 8'h00, 0,
                0, 0, 0, 7);
        run_txn(3'd3, 20'h00101, 8'h00, 1, 8'hE7, 0, 0, 0, 0, 0);

        for (int i = 0; i < N_RAND; i++) begin
            r_op[i]   = 3'($urandom_range(0, 7));
            r_addr[i] = 20'($urandom);
            r_data[i] = 8'($urandom);
            r_w[i]    = ($urandom_range(0, 5) == 0) ?
                        int'($urandom_range(WAIT_MAX - 1, WAIT_MAX + 3)) :
                        int'($urandom_range(0, 3));
        end
        for (int i = 0; i < N_RAND; i++) begin
            bit h;
            h = (i + 1 < N_RAND) && r_op[i] >= 3'd1 && r_op[i] <= 3'd4 &&
                ($urandom_range(0, 1) == 1);
            run_txn(r_op[i], r_addr[i], r_data[i], r_w[i], 8'($urandom), h,
                    h ? r_op[i+1] : 3'd0, h ? r_addr[i+1] : 20'd0,
                    h ? r_data[i+1] : 8'd0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
